vga_stream_sync: RTL and testbench

VGA_STREAM_SYNC -- requirements
Module: vga_stream_sync

---
 rtl/vga_pkg.sv | 18 +
 rtl/vga_timing_gen.sv | 52 +++++
 rtl/vga_stream_sync.sv | 139 +++++++++++++
 tb/tb_vga_stream_sync.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA stream synchroniser.
package vga_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int unsigned H_ACTIVE  = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_RETRACE = 96;
  localparam int unsigned V_ACTIVE  = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_RETRACE = 2;

endpackage

// File: rtl/vga_timing_gen.sv
// Raster position counters and combinational sync/active-area decode.
module vga_timing_gen #(
  parameter int unsigned HD = 640,
  parameter int unsigned HF = 16,
  parameter int unsigned HB = 48,
  parameter int unsigned HR = 96,
  parameter int unsigned VD = 480,
  parameter int unsigned VF = 10,
  parameter int unsigned VB = 33,
  parameter int unsigned VR = 2,
  parameter int unsigned HW = $clog2(HD + HF + HB + HR),
  parameter int unsigned VW = $clog2(VD + VF + VB + VR)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_en_i,
  output logic [HW-1:0] hc_o,
  output logic [VW-1:0] vc_o,
  output logic          video_on_c,
  output logic          hsync_raw_c,
  output logic          vsync_raw_c
);

  localparam int unsigned HT = HD + HF + HB + HR;
  localparam int unsigned VT = VD + VF + VB + VR;

  logic [HW-1:0] hc_q;
  logic [VW-1:0] vc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hc_q <= '0;
      vc_q <= '0;
    end else if (pix_en_i) begin
      if (hc_q == HW'(HT - 1)) begin
        hc_q <= '0;
        vc_q <= (vc_q == VW'(VT - 1)) ? '0 : vc_q + VW'(1);
      end else begin
        hc_q <= hc_q + HW'(1);
      end
    end
  end

  // Decode in 32 bits so porch sums never overflow the narrow counters.
  assign video_on_c  = (32'(hc_q) < HD) && (32'(vc_q) < VD);
  assign hsync_raw_c = (32'(hc_q) >= HD + HF) && (32'(hc_q) < HD + HF + HR);
  assign vsync_raw_c = (32'(vc_q) >= VD + VF) && (32'(vc_q) < VD + VF + VR);

  assign hc_o = hc_q;
  assign vc_o = vc_q;

endmodule

// File: rtl/vga_stream_sync.sv
// Aligns a start-of-frame tagged pixel stream to the VGA raster and drives
// registered sync/colour outputs with sticky underrun/misalignment flags.
module vga_stream_sync
  import vga_pkg::*;
#(
  parameter int unsigned    CD       = 12,
  parameter int unsigned    HD       = H_ACTIVE,
  parameter int unsigned    HF       = H_FRONT,
  parameter int unsigned    HB       = H_BACK,
  parameter int unsigned    HR       = H_RETRACE,
  parameter int unsigned    VD       = V_ACTIVE,
  parameter int unsigned    VF       = V_FRONT,
  parameter int unsigned    VB       = V_BACK,
  parameter int unsigned    VR       = V_RETRACE,
  parameter bit             SYNC_POL = 1'b0,
  parameter logic [CD-1:0]  BLANK    = '0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                pix_en,
  input  logic [CD:0]                         si_data,
  input  logic                                si_valid,
  output logic                                si_ready,
  output logic                                hsync,
  output logic                                vsync,
  output logic [CD-1:0]                       rgb,
  output logic [$clog2(HD+HF+HB+HR)-1:0]      hc,
  output logic [$clog2(VD+VF+VB+VR)-1:0]      vc,
  output logic                                frame_start,
  output logic                                locked,
  output logic [1:0]                          err,
  input  logic                                err_clr
);

  localparam int unsigned HW = $clog2(HD + HF + HB + HR);
  localparam int unsigned VW = $clog2(VD + VF + VB + VR);

  logic [HW-1:0] hc_w;
  logic [VW-1:0] vc_w;
  logic          video_on;
  logic          hsync_raw;
  logic          vsync_raw;

  vga_timing_gen #(
    .HD(HD), .HF(HF), .HB(HB), .HR(HR),
    .VD(VD), .VF(VF), .VB(VB), .VR(VR),
    .HW(HW), .VW(VW)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .pix_en_i    (pix_en),
    .hc_o        (hc_w),
    .vc_o        (vc_w),
    .video_on_c  (video_on),
    .hsync_raw_c (hsync_raw),
    .vsync_raw_c (vsync_raw)
  );

  state_t        state_q, state_d;
  logic [CD-1:0] rgb_q, rgb_d;
  logic          hsync_q, vsync_q;
  logic          frame_start_q;
  logic [1:0]    err_q, err_d, err_set;
  logic          ready_c;
  logic          at_origin;
  logic          sof;
  logic [CD-1:0] word_rgb;

  assign at_origin = (hc_w == '0) && (vc_w == '0);
  assign sof       = si_data[CD];
  assign word_rgb  = si_data[CD-1:0];

  // Handshake and next-pixel decision; nothing moves without a pixel tick.
  always_comb begin
    state_d = state_q;
    rgb_d   = BLANK;
    err_set = 2'b00;
    ready_c = 1'b0;
    if (pix_en) begin
      unique case (state_q)
        SEARCH: begin
          // Drain non-start words; hold a start word until the raster origin.
          ready_c = si_valid && (!sof || at_origin);
          if (si_valid && sof && at_origin) begin
            state_d = LOCKED;
            rgb_d   = word_rgb;
          end
        end
        LOCKED: begin
          if (video_on) begin
            if (!si_valid) begin
              err_set[0] = 1'b1;
              state_d    = SEARCH;
            end else if (sof && !at_origin) begin
              err_set[1] = 1'b1;
              state_d    = SEARCH;
            end else begin
              ready_c = 1'b1;
              rgb_d   = word_rgb;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    err_d = (err_q & ~{2{err_clr}}) | err_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= SEARCH;
      rgb_q         <= BLANK;
      hsync_q       <= !SYNC_POL;
      vsync_q       <= !SYNC_POL;
      frame_start_q <= 1'b0;
      err_q         <= 2'b00;
    end else begin
      frame_start_q <= pix_en && at_origin;
      err_q         <= err_d;
      if (pix_en) begin
        state_q <= state_d;
        rgb_q   <= rgb_d;
        hsync_q <= hsync_raw ~^ SYNC_POL;
        vsync_q <= vsync_raw ~^ SYNC_POL;
      end
    end
  end

  assign si_ready    = ready_c && !reset;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign rgb         = rgb_q;
  assign hc          = hc_w;
  assign vc          = vc_w;
  assign frame_start = frame_start_q;
  assign locked      = (state_q == LOCKED);
  assign err         = err_q;

endmodule

// File: tb/tb_vga_stream_sync.sv
// Bench for vga_stream_sync on a tiny 12x7 raster against a position-based model.
module tb_vga_stream_sync;

  localparam int HD = 8, HF = 1, HB = 1, HR = 2;
  localparam int VD = 4, VF = 1, VB = 1, VR = 1;
  localparam int HT = HD + HF + HB + HR;
  localparam int VT = VD + VF + VB + VR;
  localparam logic [11:0] BLANK = 12'hF0F;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_en = 1'b0;
  logic [12:0] si_data = '0;
  logic        si_valid = 1'b0;
  logic        si_ready;
  logic        hsync, vsync;
  logic [11:0] rgb;
  logic [3:0]  hc;
  logic [2:0]  vc;
  logic        frame_start, locked;
  logic [1:0]  err;
  logic        err_clr = 1'b0;

  vga_stream_sync #(
    .CD(12), .HD(HD), .HF(HF), .HB(HB), .HR(HR),
    .VD(VD), .VF(VF), .VB(VB), .VR(VR), .SYNC_POL(1'b0), .BLANK(BLANK)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .si_data(si_data),
    .si_valid(si_valid), .si_ready(si_ready), .hsync(hsync), .vsync(vsync),
    .rgb(rgb), .hc(hc), .vc(vc), .frame_start(frame_start), .locked(locked),
    .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model state: raster position as plain integers.
  int          mh, mv;
  bit          mlock, mhs, mvs, mfs;
  logic [1:0]  merr;
  logic [11:0] mrgb;
  logic [12:0] q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mh = 0; mv = 0; mlock = 0; merr = 2'b00; mrgb = BLANK;
    mhs = 1; mvs = 1; mfs = 0;
  endtask

  task automatic step(input bit pe, input bit gate, input bit clr);
    bit at0, von, sof, exp_rdy, nlock;
    logic [11:0] nrgb;
    logic [1:0]  set;
    @(negedge clk);
    pix_en   = pe;
    err_clr  = clr;
    si_valid = gate && (q.size() != 0);
    si_data  = (q.size() != 0) ? q[0] : 13'h0;
    at0 = (mh == 0) && (mv == 0);
    von = (mh < HD) && (mv < VD);
    sof = si_data[12];
    exp_rdy = 0; nrgb = BLANK; set = 2'b00; nlock = mlock;
    if (pe) begin
      if (!mlock) begin
        if (si_valid && at0 && sof) begin exp_rdy = 1; nlock = 1; nrgb = si_data[11:0]; end
        else if (si_valid && !sof) exp_rdy = 1;
      end else if (von) begin
        if (!si_valid) begin set = 2'b01; nlock = 0; end
        else if (sof && !at0) begin set = 2'b10; nlock = 0; end
        else begin exp_rdy = 1; nrgb = si_data[11:0]; end
      end
    end
    #1;
    chk("si_ready", 32'(si_ready), 32'(exp_rdy));
    if (exp_rdy) void'(q.pop_front());
    merr = (clr ? 2'b00 : merr) | set;
    mfs = pe && at0;
    if (pe) begin
      mrgb = nrgb; mlock = nlock;
      mhs = !((mh >= HD + HF) && (mh < HD + HF + HR));
      mvs = !((mv >= VD + VF) && (mv < VD + VF + VR));
      mh = mh + 1;
      if (mh == HT) begin mh = 0; mv = (mv + 1) % VT; end
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("rgb", 32'(rgb), 32'(mrgb));
    chk("hsync", 32'(hsync), 32'(mhs));
    chk("vsync", 32'(vsync), 32'(mvs));
    chk("hc", 32'(hc), 32'(mh));
    chk("vc", 32'(vc), 32'(mv));
    chk("frame_start", 32'(frame_start), 32'(mfs));
    chk("locked", 32'(locked), 32'(mlock));
    chk("err", 32'(err), 32'(merr));
  endtask

  task automatic do_reset(input bit check_vals);
    @(negedge clk);
    reset = 1'b1;
    #1;
    if (check_vals) begin
      chk("rst rgb", 32'(rgb), 32'(BLANK));
      chk("rst hsync", 32'(hsync), 32'd1);
      chk("rst vsync", 32'(vsync), 32'd1);
      chk("rst si_ready", 32'(si_ready), 32'd0);
      chk("rst frame_start", 32'(frame_start), 32'd0);
      chk("rst err", 32'(err), 32'd0);
      chk("rst locked", 32'(locked), 32'd0);
      chk("rst hc", 32'(hc), 32'd0);
      chk("rst vc", 32'(vc), 32'd0);
    end
    pix_en = 1'b0; si_valid = 1'b0; err_clr = 1'b0;
    q.delete();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_to(input int h, input int v);
    int n = 0;
    while (!(mh == h && mv == v)) begin
      if (n > 200) begin
        chk("run_to timeout", 32'd1, 32'd0);
        return;
      end
      n++;
      step(1, 1, 0);
    end
  endtask

  function automatic logic [12:0] word(input bit s);
    return {s, 12'($urandom)};
  endfunction

  task automatic push_burst();
    int k = $urandom_range(0, 7);
    if (k < 5) begin
      q.push_back(word(1));
      repeat (31) q.push_back(word(0));
    end else if (k == 5) begin
      repeat (3) q.push_back(word(0));
    end else if (k == 6) begin
      q.push_back(word(1));
      repeat ($urandom_range(0, 40)) q.push_back(word(0));
    end else begin
      q.push_back(word(1));
    end
  endtask

  typedef struct {
    int n;
    int hc;
    int vc;
    bit hs;
    bit vs;
    bit fs;
  } vec_t;

  vec_t        tbl[11];
  logic [12:0] fw[32];
  logic [12:0] c0, s2;
  int          fs_t[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Free-running raster: {ticks since reset, hc, vc, hsync, vsync, frame_start}.
    tbl[0]  = '{1, 1, 0, 1, 1, 1};
    tbl[1]  = '{2, 2, 0, 1, 1, 0};
    tbl[2]  = '{10, 10, 0, 0, 1, 0};
    tbl[3]  = '{11, 11, 0, 0, 1, 0};
    tbl[4]  = '{12, 0, 1, 1, 1, 0};
    tbl[5]  = '{61, 1, 5, 1, 0, 0};
    tbl[6]  = '{70, 10, 5, 0, 0, 0};
    tbl[7]  = '{72, 0, 6, 1, 0, 0};
    tbl[8]  = '{73, 1, 6, 1, 1, 0};
    tbl[9]  = '{84, 0, 0, 1, 1, 0};
    tbl[10] = '{85, 1, 0, 1, 1, 1};

    model_reset();
    do_reset(1);

    for (int i = 0; i < 11; i++) begin
      while (cyc < tbl[i].n) step(1, 0, 0);
      chk("tbl hc", 32'(hc), 32'(tbl[i].hc));
      chk("tbl vc", 32'(vc), 32'(tbl[i].vc));
      chk("tbl hsync", 32'(hsync), 32'(tbl[i].hs));
      chk("tbl vsync", 32'(vsync), 32'(tbl[i].vs));
      chk("tbl frame_start", 32'(frame_start), 32'(tbl[i].fs));
      chk("tbl rgb", 32'(rgb), 32'(BLANK));
    end

    // Junk then one full frame: drain, lock at origin, 32 pixels one tick late.
    repeat (5) q.push_back(word(0));
    fw[0] = word(1);
    for (int i = 1; i < 32; i++) fw[i] = word(0);
    for (int i = 0; i < 32; i++) q.push_back(fw[i]);
    run_to(0, 0);
    step(1, 1, 0);
    chk("lock locked", 32'(locked), 32'd1);
    chk("lock first pixel", 32'(rgb), 32'(fw[0][11:0]));
    run_to(8, 3);
    chk("frame last pixel", 32'(rgb), 32'(fw[31][11:0]));
    chk("frame err", 32'(err), 32'd0);

    // Underrun at (3,1).
    q.push_back(word(1));
    repeat (10) q.push_back(word(0));
    run_to(3, 1);
    step(1, 1, 0);
    chk("underrun rgb", 32'(rgb), 32'(BLANK));
    chk("underrun err", 32'(err), 32'd1);
    chk("underrun locked", 32'(locked), 32'd0);

    // Relock, then a start word arriving at (5,2).
    c0 = word(1);
    s2 = word(1);
    q.push_back(c0);
    repeat (20) q.push_back(word(0));
    q.push_back(s2);
    repeat (31) q.push_back(word(0));
    step(1, 1, 1);
    chk("err cleared", 32'(err), 32'd0);
    run_to(0, 0);
    step(1, 1, 0);
    chk("relock locked", 32'(locked), 32'd1);
    chk("relock pixel", 32'(rgb), 32'(c0[11:0]));
    run_to(5, 2);
    step(1, 1, 0);
    chk("misalign err", 32'(err), 32'd2);
    chk("misalign locked", 32'(locked), 32'd0);
    chk("misalign rgb", 32'(rgb), 32'(BLANK));
    run_to(0, 0);
    step(1, 1, 0);
    chk("held start locked", 32'(locked), 32'd1);
    chk("held start pixel", 32'(rgb), 32'(s2[11:0]));

    // Reset while locked at (4,3), then clear coinciding with a new underrun.
    run_to(4, 3);
    do_reset(1);
    q.push_back(word(1));
    repeat (2) q.push_back(word(0));
    step(1, 1, 0);
    chk("post-reset lock", 32'(locked), 32'd1);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 1);
    chk("set beats clear", 32'(err), 32'd1);
    chk("post-underrun locked", 32'(locked), 32'd0);

    // One pixel tick in four: frame period stretches to 336 clocks.
    do_reset(0);
    q.push_back(word(1));
    repeat (31) q.push_back(word(0));
    for (int i = 0; i < 1000; i++) begin
      step((i % 4) == 0, 1, 0);
      if (frame_start === 1'b1) fs_t.push_back(cyc);
    end
    chk("slow fs count", 32'(fs_t.size() >= 2), 32'd1);
    if (fs_t.size() >= 2) chk("slow frame period", 32'(fs_t[1] - fs_t[0]), 32'd336);

    // Random stream, gaps, pixel ticks and clears.
    do_reset(0);
    for (int i = 0; i < 2500; i++) begin
      if (q.size() < 3) push_burst();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) != 0, $urandom_range(0, 31) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
